// File: rtl/leaf_router_rr.sv
// rtl/leaf_router_rr.sv - leaf router: per-port input FIFOs, local-to-spine routing, round-robin arbitration onto the NI port; ROUTER_STATS_EN adds delivery counters
module leaf_router_rr #(
  parameter int NUM_SPINES = 4,
  parameter int DWIDTH     = 16,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int LOCAL_ID   = 29
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [DWIDTH-1:0]            local_in_data,
  input  logic                         local_in_valid,
  output logic                         local_in_ready,
  output logic [DWIDTH-1:0]            local_out_data,
  output logic                         local_out_valid,
  input  logic                         local_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [7:0]                   drop_count
`ifdef ROUTER_STATS_EN
  ,
  output logic [31:0]                  stat_local_flits,
  output logic [31:0]                  stat_spine_flits
`endif
);

  // Ports 0..NUM_SPINES-1 are spines; port NUM_SPINES is the local NI.
  localparam int NP  = NUM_SPINES + 1;
  localparam int LOC = NUM_SPINES;
  localparam int PW  = $clog2(NP);
  localparam int PW1 = PW + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1;
  localparam logic [ADDR_W-1:0] MY_ID = ADDR_W'(LOCAL_ID);

  logic [NP-1:0][DWIDTH-1:0] in_data;
  logic [NP-1:0][DWIDTH-1:0] head_data;
  logic [NP-1:0]             in_valid;
  logic [NP-1:0]             in_rdy;
  logic [NP-1:0]             not_empty;
  logic [NP-1:0]             push;
  logic [NP-1:0]             pop;
  logic [NP-1:0]             req;

  logic [ADDR_W-1:0]         loc_dest;
  logic                      loc_is_me;
  logic [SW-1:0]             tgt;
  logic [NUM_SPINES-1:0]     spine_free;
  logic [NUM_SPINES-1:0]     spine_load;
  logic                      route_go;

  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             arb_idx;
  logic                      arb_valid;
  logic                      grant_en;
  logic [3:0]                drop_inc;
  logic [8:0]                drop_sum;

  genvar p;
  generate
    for (p = 0; p < NP; p++) begin : g_port
      logic [DWIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     wr_ptr;
      logic [AW-1:0]     rd_ptr;
      logic [CW-1:0]     count;

      if (p < NUM_SPINES) begin : g_spine
        assign in_data[p]  = spine_in_data[p*DWIDTH +: DWIDTH];
        assign in_valid[p] = spine_in_valid[p];
        // Misrouted spine flits are accepted but never stored.
        assign push[p] = in_valid[p] && in_rdy[p] &&
                         (in_data[p][DWIDTH-1 -: ADDR_W] == MY_ID);
      end else begin : g_local
        assign in_data[p]  = local_in_data;
        assign in_valid[p] = local_in_valid;
        assign push[p]     = in_valid[p] && in_rdy[p];
      end

      // Ready comes from the registered count, so a full FIFO refuses pushes even while popping.
      assign in_rdy[p]    = (count != CW'(FIFO_DEPTH));
      assign not_empty[p] = (count != '0);
      assign head_data[p] = mem[rd_ptr];

      // Storage array: no reset needed, contents are qualified by count.
      always_ff @(posedge ACLK) begin
        if (push[p]) mem[wr_ptr] <= in_data[p];
      end

      // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push[p]) wr_ptr <= wr_ptr + AW'(1);
          if (pop[p])  rd_ptr <= rd_ptr + AW'(1);
          case ({push[p], pop[p]})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

  assign spine_in_ready = in_rdy[NUM_SPINES-1:0];
  assign local_in_ready = in_rdy[LOC];

  assign loc_dest  = head_data[LOC][DWIDTH-1 -: ADDR_W];
  assign loc_is_me = (loc_dest == MY_ID);
  assign tgt       = (NUM_SPINES > 1) ? loc_dest[SW-1:0] : '0;

  assign req[NUM_SPINES-1:0] = not_empty[NUM_SPINES-1:0];
  assign req[LOC]            = not_empty[LOC] && loc_is_me;

  // Local head routing to a spine output; blocks in place if the target register is busy.
  always_comb begin
    spine_free = '0;
    spine_load = '0;
    for (int j = 0; j < NUM_SPINES; j++) begin
      spine_free[j] = !spine_out_valid[j] || spine_out_ready[j];
    end
    route_go = not_empty[LOC] && !loc_is_me && spine_free[tgt];
    for (int j = 0; j < NUM_SPINES; j++) begin
      spine_load[j] = route_go && (tgt == SW'(j));
    end
  end

  // Round-robin search over NP requesters starting at rr_ptr.
  always_comb begin
    logic [PW1-1:0] idx;
    arb_valid = 1'b0;
    arb_idx   = '0;
    idx       = '0;
    for (int off = 0; off < NP; off++) begin
      idx = {1'b0, rr_ptr} + PW1'(off);
      if (idx >= PW1'(NP)) idx = idx - PW1'(NP);
      if (!arb_valid && req[idx[PW-1:0]]) begin
        arb_valid = 1'b1;
        arb_idx   = idx[PW-1:0];
      end
    end
  end

  assign grant_en = arb_valid && (!local_out_valid || local_out_ready);

  // FIFO pops: spine heads only via the arbiter; the local head via routing or loopback grant.
  always_comb begin
    pop = '0;
    for (int j = 0; j < NUM_SPINES; j++) begin
      pop[j] = grant_en && (arb_idx == PW'(j));
    end
    pop[LOC] = route_go || (grant_en && (arb_idx == PW'(LOC)));
  end

  // Spine output registers: load from the local head, otherwise clear on drain.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      spine_out_valid <= '0;
      spine_out_data  <= '0;
    end else begin
      for (int j = 0; j < NUM_SPINES; j++) begin
        if (spine_load[j]) begin
          spine_out_valid[j]                 <= 1'b1;
          spine_out_data[j*DWIDTH +: DWIDTH] <= head_data[LOC];
        end else if (spine_out_ready[j]) begin
          spine_out_valid[j] <= 1'b0;
        end
      end
    end
  end

  // Local output register and round-robin pointer advance on each grant.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      local_out_valid <= 1'b0;
      local_out_data  <= '0;
      rr_ptr          <= '0;
    end else begin
      if (grant_en) begin
        local_out_valid <= 1'b1;
        local_out_data  <= head_data[arb_idx];
        rr_ptr          <= (arb_idx == PW'(NP - 1)) ? '0 : arb_idx + PW'(1);
      end else if (local_out_ready) begin
        local_out_valid <= 1'b0;
      end
    end
  end

  // Number of misrouted spine flits accepted this cycle.
  always_comb begin
    drop_inc = '0;
    for (int j = 0; j < NUM_SPINES; j++) begin
      if (in_valid[j] && in_rdy[j] && (in_data[j][DWIDTH-1 -: ADDR_W] != MY_ID)) begin
        drop_inc = drop_inc + 4'd1;
      end
    end
    drop_sum = {1'b0, drop_count} + 9'(drop_inc);
  end

  // Saturating misroute counter.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

`ifdef ROUTER_STATS_EN
  logic [3:0]  spine_hs;
  logic [32:0] local_sum;
  logic [32:0] spine_sum;

  // Delivery handshakes this cycle and saturating next values.
  always_comb begin
    spine_hs = '0;
    for (int j = 0; j < NUM_SPINES; j++) begin
      if (spine_out_valid[j] && spine_out_ready[j]) spine_hs = spine_hs + 4'd1;
    end
    local_sum = {1'b0, stat_local_flits} + 33'(local_out_valid && local_out_ready);
    spine_sum = {1'b0, stat_spine_flits} + 33'(spine_hs);
  end

  // Saturating delivery counters.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stat_local_flits <= '0;
      stat_spine_flits <= '0;
    end else begin
      stat_local_flits <= local_sum[32] ? 32'hFFFF_FFFF : local_sum[31:0];
      stat_spine_flits <= spine_sum[32] ? 32'hFFFF_FFFF : spine_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_leaf_router_rr.sv
// tb/tb_leaf_router_rr.sv - self-checking bench for leaf_router_rr
module tb_leaf_router_rr;
  localparam int NS = 4;
  localparam int DW = 16;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [DW-1:0]   local_in_data;
  logic            local_in_valid;
  logic            local_in_ready;
  logic [DW-1:0]   local_out_data;
  logic            local_out_valid;
  logic            local_out_ready;
  logic [NS*DW-1:0] spine_in_data;
  logic [NS-1:0]   spine_in_valid;
  logic [NS-1:0]   spine_in_ready;
  logic [NS*DW-1:0] spine_out_data;
  logic [NS-1:0]   spine_out_valid;
  logic [NS-1:0]   spine_out_ready;
  logic [7:0]      drop_count;
`ifdef ROUTER_STATS_EN
  logic [31:0]     stat_local_flits;
  logic [31:0]     stat_spine_flits;
`endif

  leaf_router_rr dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .local_in_data   (local_in_data),
    .local_in_valid  (local_in_valid),
    .local_in_ready  (local_in_ready),
    .local_out_data  (local_out_data),
    .local_out_valid (local_out_valid),
    .local_out_ready (local_out_ready),
    .spine_in_data   (spine_in_data),
    .spine_in_valid  (spine_in_valid),
    .spine_in_ready  (spine_in_ready),
    .spine_out_data  (spine_out_data),
    .spine_out_valid (spine_out_valid),
    .spine_out_ready (spine_out_ready),
    .drop_count      (drop_count)
`ifdef ROUTER_STATS_EN
    ,
    .stat_local_flits(stat_local_flits),
    .stat_spine_flits(stat_spine_flits)
`endif
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  typedef struct {
    logic        l_v;
    logic [15:0] l_d;
    logic [3:0]  s_v;
    logic [15:0] s_d;
    logic [3:0]  so_rdy;
    logic        lo_rdy;
    logic        e_lo_v;
    logic [15:0] e_lo_d;
    logic [3:0]  e_so_v;
    logic [15:0] e_so_d;
  } vec_t;

  vec_t vt[11];
  logic [15:0] got_q[$];
  int acc;
  logic r;
  logic seen;

  initial begin
    vt[0]  = '{1'b1, 16'h0812, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000};
    vt[1]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b0, 16'h0000, 4'h4, 16'h0812};
    vt[2]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000};
    vt[3]  = '{1'b1, 16'h7401, 4'h2, 16'h7410, 4'hF, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000};
    vt[4]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b1, 16'h7411, 4'h0, 16'h0000};
    vt[5]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b1, 16'h7401, 4'h0, 16'h0000};
    vt[6]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000};
    vt[7]  = '{1'b1, 16'h0C03, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000};
    vt[8]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h8, 16'h0C03};
    vt[9]  = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h8, 16'h0C03};
    vt[10] = '{1'b0, 16'h0000, 4'h0, 16'h0000, 4'hF, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000};

    ARESETn         = 1'b0;
    local_in_data   = '0;
    local_in_valid  = 1'b0;
    local_out_ready = 1'b1;
    spine_in_data   = '0;
    spine_in_valid  = '0;
    spine_out_ready = '1;
    repeat (2) @(negedge ACLK);

    chk("rst_lo_v", 32'(local_out_valid), 32'h0);
    chk("rst_lo_d", 32'(local_out_data), 32'h0);
    chk("rst_so_v", 32'(spine_out_valid), 32'h0);
    chk("rst_so_d_lo", spine_out_data[31:0], 32'h0);
    chk("rst_so_d_hi", spine_out_data[63:32], 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    chk("rst_l_rdy", 32'(local_in_ready), 32'h1);
    chk("rst_s_rdy", 32'(spine_in_ready), 32'hF);
    ARESETn = 1'b1;
    @(negedge ACLK);

    for (int n = 0; n < 11; n++) begin
      local_in_valid  = vt[n].l_v;
      local_in_data   = vt[n].l_d;
      spine_in_valid  = vt[n].s_v;
      for (int i = 0; i < NS; i++) spine_in_data[i*DW +: DW] = vt[n].s_d | 16'(i);
      spine_out_ready = vt[n].so_rdy;
      local_out_ready = vt[n].lo_rdy;
      step();
      chk($sformatf("vec%0d_lo_v", n), 32'(local_out_valid), 32'(vt[n].e_lo_v));
      if (vt[n].e_lo_v) chk($sformatf("vec%0d_lo_d", n), 32'(local_out_data), 32'(vt[n].e_lo_d));
      chk($sformatf("vec%0d_so_v", n), 32'(spine_out_valid), 32'(vt[n].e_so_v));
      for (int i = 0; i < NS; i++)
        if (vt[n].e_so_v[i]) chk($sformatf("vec%0d_so%0d_d", n, i), 32'(spine_out_data[i*DW +: DW]), 32'(vt[n].e_so_d));
    end
    local_in_valid = 1'b0;
    spine_in_valid = '0;

    // Round-robin with all spines streaming destination-29 flits
    for (int i = 0; i < NS; i++) spine_in_data[i*DW +: DW] = 16'h7400 | 16'(i);
    spine_in_valid  = 4'hF;
    local_out_ready = 1'b1;
    spine_out_ready = 4'hF;
    step();
    chk("rr_first_lo_v", 32'(local_out_valid), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr%0d_lo_v", k), 32'(local_out_valid), 32'h1);
      chk($sformatf("rr%0d_lo_d", k), 32'(local_out_data), 32'h7400 | 32'(k % 4));
    end

    // Asynchronous reset while FIFOs hold flits
    spine_in_valid = '0;
    #1 ARESETn = 1'b0;
    #1;
    chk("amid_lo_v", 32'(local_out_valid), 32'h0);
    chk("amid_lo_d", 32'(local_out_data), 32'h0);
    chk("amid_so_v", 32'(spine_out_valid), 32'h0);
    chk("amid_so_d", spine_out_data[31:0] | spine_out_data[63:32], 32'h0);
    chk("amid_drop", 32'(drop_count), 32'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst%0d_valids", k), 32'({local_out_valid, spine_out_valid}), 32'h0);
    end

    // Backpressure on local_out with spine 0 streaming
    local_out_ready = 1'b0;
    spine_in_valid  = 4'b0001;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      spine_in_data[DW-1:0] = 16'h7400 + 16'(acc);
      r = spine_in_ready[0];
      @(posedge ACLK);
      if (r) acc++;
      @(negedge ACLK);
    end
    chk("bp_accepts", 32'(acc), 32'd5);
    chk("bp_ready_low", 32'(spine_in_ready[0]), 32'h0);
    spine_in_valid  = '0;
    local_out_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      if (local_out_valid && local_out_ready) got_q.push_back(local_out_data);
      step();
    end
    chk("bp_delivered", 32'(got_q.size()), 32'd5);
    foreach (got_q[i]) chk($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'h7400 + 32'(i));

    // Misrouted flits on spine 3
    spine_in_data[3*DW +: DW] = 16'h1403;
    spine_in_valid = 4'b1000;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (local_out_valid || (spine_out_valid != '0)) seen = 1'b1;
      if (c == 99) chk("drop_100", 32'(drop_count), 32'd100);
    end
    chk("drop_sat", 32'(drop_count), 32'd255);
    chk("drop_ready", 32'(spine_in_ready[3]), 32'h1);
    chk("drop_no_output", 32'(seen), 32'h0);
    spine_in_valid = '0;
    step();
    chk("drop_hold", 32'(drop_count), 32'd255);

`ifdef ROUTER_STATS_EN
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    spine_in_data[DW-1:0] = 16'h7455;
    local_in_data = 16'h0401;
    for (int c = 0; c < 10; c++) begin
      spine_in_valid = 4'b0001;
      local_in_valid = (c < 7);
      step();
    end
    spine_in_valid = '0;
    local_in_valid = 1'b0;
    repeat (5) step();
    chk("stat_local", stat_local_flits, 32'd10);
    chk("stat_spine", stat_spine_flits, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/leaf_router_rr.md
Name: leaf_router_rr

Overview:
- Parametrised leaf router for one GPU node tile; sits between the node's network interface (NI) and NUM_SPINES spine links.
- Replaces the fixed 4-spine, always-ready hookup with per-port input FIFOs, valid/ready backpressure, registered outputs and round-robin arbitration onto the local port.
- Flit destination address is the top ADDR_W bits of each flit.

Parameters:
- NUM_SPINES, 4, number of spine ports; power of two, 1..8.
- DWIDTH, 16, flit width in bits.
- ADDR_W, 6, destination field width; occupies flit[DWIDTH-1 -: ADDR_W].
- FIFO_DEPTH, 4, entries per input FIFO; power of two, at least 2.
- LOCAL_ID, 29, node address of this tile.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- local_in_data  in  DWIDTH  flit from NI.
- local_in_valid  in  1  NI flit valid.
- local_in_ready  out  1  local FIFO not full.
- local_out_data  out  DWIDTH  flit to NI.
- local_out_valid  out  1  flit to NI valid.
- local_out_ready  in  1  NI accepts.
- spine_in_data  in  NUM_SPINES*DWIDTH  flits from spines; port i at [i*DWIDTH +: DWIDTH].
- spine_in_valid  in  NUM_SPINES  per-spine valid.
- spine_in_ready  out  NUM_SPINES  per-spine FIFO not full.
- spine_out_data  out  NUM_SPINES*DWIDTH  flits to spines.
- spine_out_valid  out  NUM_SPINES  per-spine valid.
- spine_out_ready  in  NUM_SPINES  per-spine accept.
- drop_count  out  8  saturating count of misrouted spine flits.

Behaviour:
- Reset (ARESETn low, async): all FIFOs empty; all *_out_valid=0; all *_out_data=0; RR pointer=0; drop_count=0. Any in-flight flit is discarded; no output glitches after reset deasserts.
- Handshake: transfer when valid&&ready at the ACLK rising edge. in_ready = FIFO not full, from registered count; a push is never accepted when full, even with a simultaneous pop. An out_valid flit holds data stable until ready.
- Ingress: one FIFO per spine plus one local FIFO. A spine flit whose dest != LOCAL_ID is still accepted (ready rules unchanged), is not written, and increments drop_count; drop_count holds at 255.
- Local FIFO head, dest != LOCAL_ID: target spine s = dest[log2(NUM_SPINES)-1:0] (s=0 when NUM_SPINES=1).
  - Head moves into spine s output register when that register is empty or drains the same cycle.
  - Otherwise the head waits; head-of-line blocking is intended.
- Local FIFO head, dest == LOCAL_ID: loopback requester.
- Local output arbitration:
  - Requesters 0..NUM_SPINES-1 are the spine FIFO heads; requester NUM_SPINES is the local loopback.
  - Round-robin starting from the pointer. On a grant the pointer becomes granted+1 mod (NUM_SPINES+1). Pointer is unchanged when nothing is granted.
  - A grant occurs only when local_out register is empty or drains this cycle.
- Latency: flit accepted at edge k is loaded into its output register at edge k+1 at the earliest; out_valid is visible after edge k+1. Full throughput is one flit per cycle per output under continuous ready.
- Ordering: flits from one input to one output are never reordered.
- No combinational path from any *_in_valid or *_out_ready to any output.

Optional Feature:
- Macro ROUTER_STATS_EN.
- Defined: adds ports stat_local_flits (out, 32) and stat_spine_flits (out, 32).
  - stat_local_flits counts local_out handshakes; stat_spine_flits counts handshakes summed over all spine outputs.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-traffic: assert ARESETn low while FIFOs hold flits -> all valids 0, data 0, drop_count 0 immediately; no stale flit appears after release.
- Local-to-spine route: local_in flit 0x0812 (dest 2) -> spine 2 out_valid one cycle after acceptance with data 0x0812; other spines stay idle.
- Round-robin fairness: all 4 spines continuously send dest-29 flits (0x7400|i), NI always ready -> local_out grant sequence 0,1,2,3,0,...
- Loopback in rotation: local flit 0x7401 plus spine 1 flit 0x7411 -> both delivered in RR order; ordering per source preserved.
- Backpressure: local_out_ready=0 with spine 0 streaming -> spine_in_ready[0] drops after FIFO_DEPTH+1 accepts. Release ready -> all flits delivered in order, none lost or duplicated.
- Misroute: spine 3 sends 300 flits with dest 5 -> none on any output; drop_count reaches and holds 255.
- With ROUTER_STATS_EN: 10 local deliveries and 7 spine deliveries -> stat_local_flits=10, stat_spine_flits=7.
